// File: rtl/jk_flop_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_flop_pkg
// Brief    : Mode encodings shared by the multi-mode flop bank and its cells.
// Revision : 1.0 - initial release
// ============================================================================
package jk_flop_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_JK = 2'b00;
  localparam mode_t MODE_D  = 2'b01;
  localparam mode_t MODE_T  = 2'b10;
  localparam mode_t MODE_SR = 2'b11;

endpackage : jk_flop_pkg
`default_nettype wire

// File: rtl/jk_flop_cell.sv
`default_nettype none
// ============================================================================
// Module   : jk_flop_cell
// Brief    : One flop channel with sticky SR-illegal flag and saturating
//            toggle counter.
// Revision : 1.0 - initial release
// ============================================================================
module jk_flop_cell
  import jk_flop_pkg::*;
#(
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               en,
  input  logic               j,
  input  logic               k,
  input  logic               sclr,
  input  logic               err_clr,
  input  logic               cnt_clr,
  input  logic               rst_val,
  output logic               q,
  output logic               sr_err,
  output logic [COUNT_W-1:0] tog_cnt
);

  localparam logic [COUNT_W-1:0] c_cnt_max = '1;
  localparam logic [COUNT_W-1:0] c_cnt_one = 1;

  logic               r_q;
  logic               r_err;
  logic [COUNT_W-1:0] r_cnt;
  logic               w_eval_q;
  logic               w_illegal;
  logic               w_active;
  logic               w_toggle;

  always_comb begin
    w_eval_q  = r_q;
    w_illegal = 1'b0;
    case (mode_t'(mode))
      MODE_JK: begin
        case ({j, k})
          2'b01:   w_eval_q = 1'b0;
          2'b10:   w_eval_q = 1'b1;
          2'b11:   w_eval_q = ~r_q;
          default: w_eval_q = r_q;
        endcase
      end
      MODE_D:  w_eval_q = j;
      MODE_T:  w_eval_q = j ? ~r_q : r_q;
      default: begin
        case ({j, k})
          2'b01:   w_eval_q = 1'b0;
          2'b10:   w_eval_q = 1'b1;
          2'b11:   w_illegal = 1'b1;
          default: w_eval_q = r_q;
        endcase
      end
    endcase
  end

  // Normal evaluation only happens when enabled and not being cleared.
  assign w_active = en & ~sclr;
  assign w_toggle = w_active & (w_eval_q != r_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= rst_val;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (sclr) begin
        r_q <= rst_val;
      end else if (en) begin
        r_q <= w_eval_q;
      end

      if (w_active && w_illegal) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end

      if (cnt_clr) begin
        r_cnt <= w_toggle ? c_cnt_one : '0;
      end else if (w_toggle && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign q       = r_q;
  assign sr_err  = r_err;
  assign tog_cnt = r_cnt;

endmodule : jk_flop_cell
`default_nettype wire

// File: rtl/jk_flop_bank.sv
`default_nettype none
// ============================================================================
// Module   : jk_flop_bank
// Brief    : WIDTH-channel bank of JK/D/T/SR flops with status and counters.
// Revision : 1.0 - initial release
// ============================================================================
module jk_flop_bank #(
  parameter int               WIDTH     = 8,
  parameter int               COUNT_W   = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           en,
  input  logic [WIDTH-1:0]           j,
  input  logic [WIDTH-1:0]           k,
  input  logic                       sclr,
  input  logic                       err_clr,
  input  logic                       cnt_clr,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_bar,
  output logic [WIDTH-1:0]           sr_err,
  output logic [WIDTH*COUNT_W-1:0]   tog_cnt
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_flop_cell #(
      .COUNT_W (COUNT_W)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .mode    (mode),
      .en      (en[gi]),
      .j       (j[gi]),
      .k       (k[gi]),
      .sclr    (sclr),
      .err_clr (err_clr),
      .cnt_clr (cnt_clr),
      .rst_val (RESET_VAL[gi]),
      .q       (q[gi]),
      .sr_err  (sr_err[gi]),
      .tog_cnt (tog_cnt[gi*COUNT_W +: COUNT_W])
    );
  end : g_cell

  assign q_bar = ~q;

endmodule : jk_flop_bank
`default_nettype wire
